// File: rtl/cr_huf_comp_is_arb.sv
// cr_huf_comp_is_arb: block-granular round-robin share of one sort engine between short/long streams with a source-tag FIFO steering results back
module cr_huf_comp_is_arb #(
  parameter int DAT_WIDTH   = 10,
  parameter int CNT_WIDTH   = 10,
  parameter int SEQID_WIDTH = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sc_is_short_vld,
  input  logic [DAT_WIDTH-1:0]   sc_is_short_sym,
  input  logic [CNT_WIDTH-1:0]   sc_is_short_cnt,
  input  logic [SEQID_WIDTH-1:0] sc_is_short_seq_id,
  input  logic                   sc_is_short_eob,
  output logic                   is_sc_short_rd,
  input  logic                   sc_is_long_vld,
  input  logic [DAT_WIDTH-1:0]   sc_is_long_sym,
  input  logic [CNT_WIDTH-1:0]   sc_is_long_cnt,
  input  logic [SEQID_WIDTH-1:0] sc_is_long_seq_id,
  input  logic                   sc_is_long_eob,
  output logic                   is_sc_long_rd,
  output logic                   arb_is_vld,
  output logic [DAT_WIDTH-1:0]   arb_is_sym,
  output logic [CNT_WIDTH-1:0]   arb_is_cnt,
  output logic [SEQID_WIDTH-1:0] arb_is_seq_id,
  output logic                   arb_is_eob,
  input  logic                   is_arb_rd,
  input  logic                   is_arb_res_eob,
  output logic                   arb_is_not_ready,
  output logic                   arb_res_src,
  input  logic                   ht_is_short_not_ready,
  input  logic                   ht_is_long_not_ready,
  output logic                   arb_err_tag_underflow
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_S = 2'd1;
  localparam logic [1:0] GNT_L = 2'd2;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  logic [1:0] state, state_nxt;
  logic rr_last, gs, gl, pick, push, pop, full, empty;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [TAG_DEPTH-1:0] tag_mem;
  assign gs = state == GNT_S;
  assign gl = state == GNT_L;
  assign arb_is_vld = gs ? sc_is_short_vld : gl & sc_is_long_vld;
  assign arb_is_sym = gl ? sc_is_long_sym : sc_is_short_sym;
  assign arb_is_cnt = gl ? sc_is_long_cnt : sc_is_short_cnt;
  assign arb_is_seq_id = gl ? sc_is_long_seq_id : sc_is_short_seq_id;
  assign arb_is_eob = gl ? sc_is_long_eob : sc_is_short_eob;
  assign is_sc_short_rd = gs & sc_is_short_vld & is_arb_rd;
  assign is_sc_long_rd = gl & sc_is_long_vld & is_arb_rd;
  assign push = arb_is_vld & is_arb_rd & arb_is_eob;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = is_arb_res_eob & ~empty;
  assign arb_res_src = empty ? 1'b0 : tag_mem[rd_ptr[AW-1:0]];
  assign arb_is_not_ready = empty | (arb_res_src ? ht_is_long_not_ready : ht_is_short_not_ready);
  // both requesting: the source that did not win last time goes next
  assign pick = (sc_is_short_vld & sc_is_long_vld) ? ~rr_last : sc_is_long_vld;
  always_comb begin
    state_nxt = (gs | gl) ? (push ? IDLE : state)
              : (~full & (sc_is_short_vld | sc_is_long_vld)) ? (pick ? GNT_L : GNT_S) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_last <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      arb_err_tag_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        rr_last <= gl;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (is_arb_res_eob & empty) arb_err_tag_underflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= gl;
  end
endmodule
